// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encodings, ALU-class opcode test and the
// dispatch entry layout used by the ALU, load and store buffers.
package cpu_pkg;

   localparam int INSTR_W = 32;

   typedef enum logic [5:0] {
      OP_RTYPE = 6'b000000,
      OP_BEQ   = 6'b000100,
      OP_BNE   = 6'b000101,
      OP_BLEZ  = 6'b000110,
      OP_ADDI  = 6'b001000,
      OP_ADDIU = 6'b001001,
      OP_SLTIU = 6'b001011,
      OP_ANDI  = 6'b001100,
      OP_ORI   = 6'b001101,
      OP_XORI  = 6'b001110,
      OP_LUI   = 6'b001111,
      OP_LW    = 6'b100011,
      OP_SW    = 6'b101011
   } opcode_t;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [INSTR_W-1:0] instr_no;
   } disp_entry_t;

   function automatic logic is_alu_op(input logic [5:0] op);
      case (op)
         OP_RTYPE, OP_BLEZ, OP_ADDI, OP_ADDIU, OP_SLTIU,
         OP_ANDI, OP_ORI, OP_XORI, OP_LUI: return 1'b1;
         default:                          return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/alu_buf_fifo.sv
// In-order storage for the ALU dispatch buffer: entry array, wrapping pointers,
// occupancy counter and flush. Callers must only assert wr_en when there is room.
module alu_buf_fifo
   import cpu_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int DW    = 2 * INSTR_W
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       wr_en,
   input  logic [DW-1:0]              wr_data,
   input  logic                       rd_en,
   output logic [DW-1:0]              rd_data,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [DW-1:0] mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;

   // Storage carries no reset; the empty case is masked on the read side.
   always_ff @(posedge clk) begin
      if (wr_en && !flush && !rst) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (rd_en) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         if (wr_en && !rd_en) begin
            count <= count + CW'(1);
         end else if (rd_en && !wr_en) begin
            count <= count - CW'(1);
         end
      end
   end

   assign rd_data = (count == '0) ? '0 : mem[rd_ptr];

endmodule

// File: rtl/alu_dispatch_buffer.sv
// Receive-side ALU dispatch buffer: detects new dispatches, filters non-ALU opcodes
// and queues instructions for in-order issue. Optional same-cycle bypass: ALU_BUF_BYPASS_EN.
module alu_dispatch_buffer
   import cpu_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [W-1:0]           ALU_Instr,
   input  logic [W-1:0]           ALU_InstrNO,
   input  logic                   ALU_DR,
   output logic                   ALUbuffer_ready,
   output logic [W-1:0]           issue_instr,
   output logic [W-1:0]           issue_instr_no,
   output logic                   issue_valid,
   input  logic                   issue_ready,
   input  logic                   flush,
   output logic [$clog2(DEPTH):0] occupancy,
   output logic                   overflow_err,
   output logic                   bad_op_err
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic [W-1:0]   last_no;
   logic           seen;
   logic           new_disp;
   logic           alu_op;
   logic           fifo_valid;
   logic           fifo_full;
   logic           deq;
   logic           enq;
   logic           bypass_take;
   logic [2*W-1:0] head;

   assign new_disp   = ALU_DR && (!seen || (ALU_InstrNO != last_no));
   assign alu_op     = is_alu_op(ALU_Instr[W-1 -: 6]);
   assign fifo_valid = (occupancy != '0);
   assign fifo_full  = (occupancy == CW'(DEPTH));
   assign deq        = fifo_valid && issue_ready;

`ifdef ALU_BUF_BYPASS_EN
   assign bypass_take = new_disp && alu_op && !flush && !fifo_valid && issue_ready;
`else
   assign bypass_take = 1'b0;
`endif

   // A full buffer still accepts when the head leaves in the same cycle.
   assign enq = new_disp && alu_op && !flush && !bypass_take && (!fifo_full || deq);

   alu_buf_fifo #(
      .DEPTH (DEPTH),
      .DW    (2 * W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .flush   (flush),
      .wr_en   (enq),
      .wr_data ({ALU_Instr, ALU_InstrNO}),
      .rd_en   (deq),
      .rd_data (head),
      .count   (occupancy)
   );

   // Dispatch tracking and sticky errors; tracking updates even across a flush
   // so a held ALU_DR is never taken twice.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_no      <= '0;
         seen         <= 1'b0;
         overflow_err <= 1'b0;
         bad_op_err   <= 1'b0;
      end else if (new_disp) begin
         last_no <= ALU_InstrNO;
         seen    <= 1'b1;
         if (!alu_op) begin
            bad_op_err <= 1'b1;
         end else if (fifo_full && !deq) begin
            overflow_err <= 1'b1;
         end
      end
   end

   assign ALUbuffer_ready = (occupancy < CW'(DEPTH)) && !flush;
   assign issue_valid     = fifo_valid || bypass_take;
   assign issue_instr     = bypass_take ? ALU_Instr   : head[2*W-1:W];
   assign issue_instr_no  = bypass_take ? ALU_InstrNO : head[W-1:0];

endmodule

// File: doc/alu_dispatch_buffer.md
# alu_dispatch_buffer

Receive-side counterpart of the control unit's ALU dispatch port. Accepts ALU-class instructions tagged with their instruction number. Holds them in an in-order FIFO and issues them one per cycle to the ALU over a valid/ready handshake. Drives `ALUbuffer_ready` back to the control unit; sits between the control unit and the ALU/ROB write path.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, at least 2.
- `W`, 32: instruction and instruction-number width.

Ports:
- `clk`, in, 1: clock; all state updates on the rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `ALU_Instr`, in, W: dispatched instruction word.
- `ALU_InstrNO`, in, W: dispatched instruction number.
- `ALU_DR`, in, 1: dispatch valid. Level signal; the sender may hold it high across cycles for the same instruction.
- `ALUbuffer_ready`, out, 1: buffer can accept a new instruction.
- `issue_instr`, out, W: head instruction to the ALU.
- `issue_instr_no`, out, W: head instruction number.
- `issue_valid`, out, 1: head entry is valid.
- `issue_ready`, in, 1: ALU takes the head this cycle.
- `flush`, in, 1: discard all held entries.
- `occupancy`, out, $clog2(DEPTH)+1: number of stored entries.
- `overflow_err`, out, 1: sticky; a new dispatch was dropped because the buffer was full.
- `bad_op_err`, out, 1: sticky; a non-ALU opcode was presented.

## Operation
- ALU-class opcodes (`ALU_Instr[31:26]`): 000000, 000110, 001000, 001001, 001011, 001100, 001101, 001110, 001111.
- New-dispatch detect: `ALU_DR`=1 and either `seen`=0 or `ALU_InstrNO` != `last_no`. A held `ALU_DR` with an unchanged number is ignored.
- On a new dispatch, `last_no` is set to `ALU_InstrNO` and `seen` is set to 1, whatever the outcome below.
- Outcome of a new dispatch:
  - Opcode not ALU-class: not enqueued; `bad_op_err` is set.
  - Otherwise, enqueue at the tail if `occupancy`<DEPTH, or if `occupancy`==DEPTH and a dequeue occurs in the same cycle.
  - Otherwise (full, no dequeue): dropped; `overflow_err` is set.
- Dequeue: `issue_valid` && `issue_ready`; the head pointer advances.
- Simultaneous enqueue and dequeue: `occupancy` is unchanged.
- Pointers are `$clog2(DEPTH)` bits wide and wrap modulo DEPTH. The full/empty decision comes from `occupancy`, not from pointer compare.
- `flush`=1: pointers and `occupancy` go to 0. Any enqueue in that cycle is discarded. `last_no`/`seen` still update, so a held `ALU_DR` is not re-accepted after the flush. Flush takes priority over enqueue and dequeue.
- `ALUbuffer_ready` = (`occupancy` < DEPTH) && !`flush`, combinational from registered state.
- `issue_*` outputs are driven from the head entry. When empty, `issue_instr` and `issue_instr_no` are 0.
- Sticky error flags clear only on `rst`.

## Timing
- Reset values: `ALUbuffer_ready`=1, `issue_valid`=0, `issue_instr`=0, `issue_instr_no`=0, `occupancy`=0, both error flags 0, `seen`=0, `last_no`=0.
- Reset mid-operation discards all entries in the same edge.
- Enqueue-to-issue latency: 1 cycle. An entry written at edge N shows `issue_valid`=1 after edge N.
- Throughput: one enqueue and one dequeue per cycle.
- `ALUbuffer_ready` drops in the cycle after the enqueue that fills the buffer.
- `issue_*` outputs are stable while `issue_valid`=1 and `issue_ready`=0.

## Configuration
- `ALU_BUF_BYPASS_EN` defined: when the buffer is empty, `flush`=0, a new valid ALU dispatch arrives and `issue_ready`=1, the instruction appears on `issue_*` with `issue_valid`=1 combinationally in the same cycle. It is consumed and not stored, and `occupancy` stays 0.
- `ALU_BUF_BYPASS_EN` undefined: no bypass; latency is always 1 cycle.

## Structure
- Shared package `cpu_pkg` holds:
  - `INSTR_W`=32.
  - Opcode constants: `OP_RTYPE`, `OP_ADDI`, `OP_ADDIU`, `OP_LW`=100011, `OP_SW`=101011, `OP_BEQ`, `OP_BNE`, etc.
  - Function `is_alu_op(op)`, shared with the load and store buffers.
  - Packed struct `disp_entry_t` {instr, instr_no}.
- One sub-module, `alu_buf_fifo`: storage array, pointers, occupancy, and flush. Dispatch detect, opcode check, errors and bypass stay in the top.

## Test plan
- Reset, then hold `ALU_DR`=1 with instruction 0x20010005 / number 0 for 3 cycles, `issue_ready`=0 → `occupancy`=1 (single accept), `issue_instr`=0x20010005, `issue_instr_no`=0.
- Dispatch numbers 1..5 (ALU ops) on consecutive cycles, `issue_ready`=0, DEPTH=4 → `ALUbuffer_ready`=0 after the 4th, number 5 dropped, `overflow_err`=1, `occupancy`=4.
- Full buffer, `issue_ready`=1 and new dispatch number 9 in the same cycle → accepted, `occupancy` stays 4, head advances by one, number 9 at the tail.
- Dispatch 0x8C220000 (lw) number 7 → not enqueued, `bad_op_err`=1, `occupancy` unchanged.
- 3 entries held, `flush`=1 while `ALU_DR` is held with number 12 → `occupancy`=0 after the edge; in the next cycle with `flush`=0 and number 12 still held → not re-accepted.
- With `ALU_BUF_BYPASS_EN`: empty buffer, `issue_ready`=1, dispatch number 20 → `issue_valid`=1 and `issue_instr_no`=20 in the same cycle, `occupancy`=0. Without the macro: `issue_valid` appears one cycle later.
